// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg
// Shared definitions for the FIFO pop-side controller: FSM state encoding,
// default data/counter widths and the burst-start predicate.
package fifo_reader_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int CNT_W_DEF  = 8;

  // Encoding 2'b11 is unused; the FSM recovers from it to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  // A fresh burst needs the FIFO filled past its almost-empty threshold,
  // unless flush asks to drain whatever is there.
  function automatic logic burst_start(input logic enable,
                                       input logic empty,
                                       input logic almost_empty,
                                       input logic flush,
                                       input logic dest_af);
    return enable & ~empty & ~dest_af & (~almost_empty | flush);
  endfunction

endpackage

// File: rtl/fifo_reader_out_stage.sv
// fifo_reader_out_stage
// Read pipeline behind the pop request: delays the pop by one cycle to line
// up with the registered FIFO read data, captures that data into a one-word
// output stage with a single-cycle valid strobe, and counts forwarded words.
//
// Ports:
//   clk, reset   clock, async active-high reset
//   pop          pop issued to the FIFO this cycle
//   fifo_data    FIFO read data (valid the cycle after pop)
//   data_out     captured word, holds between strobes
//   valid_out    one-cycle strobe per captured word
//   word_count   forwarded words, wraps modulo 2^CNT_W
//   pop_d1       a read is in flight (data arrives this cycle)
module fifo_reader_out_stage
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pop,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  word_count,
  output logic              pop_d1
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pop_d1     <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      word_count <= '0;
    end else begin
      pop_d1 <= pop;
      // An in-flight word is delivered regardless of FSM state or backpressure.
      if (pop_d1) begin
        data_out   <= fifo_data;
        valid_out  <= 1'b1;
        word_count <= word_count + CNT_W'(1);
      end else begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader
// Pop-side controller for the transaction-layer FIFO. Waits for a burst's
// worth of data (or flush), pops one word per cycle while the downstream
// stage has room, and forwards the words through fifo_reader_out_stage.
//
// state  | meaning
// IDLE   | not reading; waits for enable, data past threshold (or flush), room
// ACTIVE | popping one word per cycle while data and room are available
// HOLD   | paused by downstream backpressure; resumes without the burst rule
//
// Ports:
//   clk, reset          clock, async active-high reset
//   enable              allow leaving IDLE and keep popping
//   flush               start on any non-empty FIFO
//   fifo_empty          FIFO empty flag
//   fifo_almost_empty   FIFO lower-threshold flag
//   fifo_data           FIFO read data, valid the cycle after fifo_pop
//   dest_almost_full    downstream backpressure
//   fifo_pop            pop request (combinational)
//   data_out, valid_out forwarded word and its strobe
//   idle                IDLE with nothing in flight
//   word_count          forwarded-word counter, wraps
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic              fifo_empty,
  input  logic              fifo_almost_empty,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              dest_almost_full,
  output logic              fifo_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              idle,
  output logic [CNT_W-1:0]  word_count
);

  state_t state;
  logic   pop_d1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (burst_start(enable, fifo_empty, fifo_almost_empty, flush,
                          dest_almost_full))
            state <= ACTIVE;
        end
        ACTIVE: begin
          // Stopping wins over pausing.
          if (fifo_empty || !enable)
            state <= IDLE;
          else if (dest_almost_full)
            state <= HOLD;
        end
        HOLD: begin
          if (fifo_empty || !enable)
            state <= IDLE;
          else if (!dest_almost_full)
            state <= ACTIVE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mealy pop so backpressure and empty cut the request in the same cycle.
  assign fifo_pop = (state == ACTIVE) & enable & ~fifo_empty & ~dest_almost_full;

  fifo_reader_out_stage #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_out_stage (
    .clk        (clk),
    .reset      (reset),
    .pop        (fifo_pop),
    .fifo_data  (fifo_data),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .word_count (word_count),
    .pop_d1     (pop_d1)
  );

  assign idle = (state == IDLE) & ~pop_d1 & ~valid_out;

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;
  import fifo_reader_pkg::*;

  localparam int DW     = 10;
  localparam int CW     = 8;
  localparam int THRESH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          flush;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic [DW-1:0] fifo_data;
  logic          dest_almost_full;
  logic          fifo_pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          idle;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  fifo_reader #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .flush             (flush),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_data         (fifo_data),
    .dest_almost_full  (dest_almost_full),
    .fifo_pop          (fifo_pop),
    .data_out          (data_out),
    .valid_out         (valid_out),
    .idle              (idle),
    .word_count        (word_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Behavioural FIFO: pushes are written by the stimulus, pops by the DUT.
  logic [DW-1:0] mem [0:1023];
  logic [9:0]    wr_ptr;
  logic [9:0]    rd_ptr;
  logic [9:0]    fill;

  assign fill              = wr_ptr - rd_ptr;
  assign fifo_empty        = (fill == 10'd0);
  assign fifo_almost_empty = (fill <= 10'(THRESH));

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= wr_ptr;
      fifo_data <= '0;
    end else if (fifo_pop) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 10'd1;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 10'd1;
  endtask

  // Scoreboard: delivered words must equal the pushed stream in order;
  // a reset drops everything pushed so far.
  logic [9:0] exp_ptr;
  int         tb_count;

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      exp_ptr  = wr_ptr;
      tb_count = 0;
    end else begin
      if (fifo_empty) check("pop_while_empty", 32'(fifo_pop), 32'd0);
      if (valid_out) begin
        check("data_order", 32'(data_out), 32'(mem[exp_ptr]));
        exp_ptr  = exp_ptr + 10'd1;
        tb_count = tb_count + 1;
        check("word_count_run", 32'(word_count), 32'(tb_count % 256));
      end
    end
  end

  // Per-phase statistics, owned by the stimulus process.
  int   tcyc, pop_n, val_n, first_pop, last_pop, first_val, last_val;
  logic last_pop_s;

  task automatic clear_stats();
    pop_n = 0; val_n = 0;
    first_pop = -1; last_pop = -1; first_val = -1; last_val = -1;
  endtask

  task automatic step();
    @(negedge clk);
    if (fifo_pop) begin
      if (pop_n == 0) first_pop = tcyc;
      last_pop = tcyc;
      pop_n++;
    end
    if (valid_out) begin
      if (val_n == 0) first_val = tcyc;
      last_val = tcyc;
      val_n++;
    end
    last_pop_s = fifo_pop;
    @(posedge clk);
    #1;
    tcyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pops(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && pop_n < target; i++) step();
    check(tag, 32'(pop_n), 32'(target));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_t, v_n;
    logic [DW-1:0] w;

    wr_ptr = '0;
    enable = 1'b0; flush = 1'b0; dest_almost_full = 1'b0;
    reset  = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pop",   32'(fifo_pop),   32'd0);
    check("rst_data",  32'(data_out),   32'd0);
    check("rst_valid", 32'(valid_out),  32'd0);
    check("rst_idle",  32'(idle),       32'd1);
    check("rst_count", 32'(word_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tcyc  = 0;

    // Burst of 6 words above threshold.
    clear_stats();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) push(DW'(10'h101 + i));
    start_t = tcyc;
    run(15);
    check("t1_pops",        32'(pop_n),              32'd6);
    check("t1_start_lat",   32'(first_pop - start_t), 32'd1);
    check("t1_pop_span",    32'(last_pop - first_pop), 32'd5);
    check("t1_valids",      32'(val_n),              32'd6);
    check("t1_read_lat",    32'(first_val - first_pop), 32'd2);
    check("t1_valid_span",  32'(last_val - first_val), 32'd5);
    check("t1_last_data",   32'(data_out),           32'h106);
    check("t1_count",       32'(word_count),         32'd6);
    check("t1_idle",        32'(idle),               32'd1);

    // Single word below threshold waits for flush.
    clear_stats();
    w = DW'($urandom);
    push(w);
    run(20);
    check("t2_no_pop", 32'(pop_n), 32'd0);
    flush = 1'b1;
    run(6);
    flush = 1'b0;
    check("t2_one_pop", 32'(pop_n),      32'd1);
    check("t2_valid",   32'(val_n),      32'd1);
    check("t2_data",    32'(data_out),   32'(w));
    check("t2_count",   32'(word_count), 32'd7);

    // Backpressure after the 3rd pop.
    clear_stats();
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    wait_pops(3, 30, "t3_reach3");
    dest_almost_full = 1'b1;
    step();
    check("t3_pop_stops", 32'(last_pop_s), 32'd0);
    v_n = val_n;
    run(4);
    check("t3_extra_valid", 32'(val_n - v_n), 32'd1);
    check("t3_held_pops",   32'(pop_n),       32'd3);
    check("t3_state_hold",  32'(dut.state),   32'(HOLD));
    dest_almost_full = 1'b0;
    run(15);
    check("t3_pops",   32'(pop_n),      32'd8);
    check("t3_valids", 32'(val_n),      32'd8);
    check("t3_count",  32'(word_count), 32'd15);

    // Enable dropped after the 2nd pop.
    clear_stats();
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    wait_pops(2, 30, "t4_reach2");
    enable = 1'b0;
    run(10);
    check("t4_pops",     32'(pop_n),     32'd2);
    check("t4_valids",   32'(val_n),     32'd2);
    check("t4_state",    32'(dut.state), 32'(IDLE));
    check("t4_idle",     32'(idle),      32'd1);
    check("t4_left",     32'(fill),      32'd4);

    // Asynchronous reset in the middle of a burst.
    clear_stats();
    enable = 1'b1;
    for (int i = 0; i < 6; i++) push(DW'($urandom));
    wait_pops(3, 30, "t5_reach3");
    #2 reset = 1'b1;
    #1;
    check("t5_pop",   32'(fifo_pop),   32'd0);
    check("t5_data",  32'(data_out),   32'd0);
    check("t5_valid", 32'(valid_out),  32'd0);
    check("t5_idle",  32'(idle),       32'd1);
    check("t5_count", 32'(word_count), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    clear_stats();
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    run(15);
    check("t5_restart_valids", 32'(val_n),      32'd5);
    check("t5_restart_count",  32'(word_count), 32'd5);
    check("t5_restart_idle",   32'(idle),       32'd1);

    // 260-word stream with random backpressure; counter wraps.
    #2 reset = 1'b1;
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_stats();
    for (int i = 0; i < 260; i++) push(DW'($urandom));
    for (int i = 0; i < 1500 && pop_n < 260; i++) begin
      dest_almost_full = ($urandom_range(0, 3) == 0);
      step();
    end
    dest_almost_full = 1'b0;
    run(8);
    check("t6_pops",   32'(pop_n),      32'd260);
    check("t6_valids", 32'(val_n),      32'd260);
    check("t6_count",  32'(word_count), 32'd4);
    check("t6_idle",   32'(idle),       32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
